// File: rtl/sram_arbiter.sv
// Arbitrates one priority read port and NUM_WR_CH round-robin write ports onto a
// single-ported SRAM, with write starvation protection and a read-data valid strobe.
module sram_arbiter #(
    parameter int NUM_WR_CH  = 2,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2,
    parameter int MAX_WAIT   = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_data_valid,
    output logic [DATA_W-1:0]         rd_data,
    input  logic [NUM_WR_CH-1:0]      wr_valid,
    output logic [NUM_WR_CH-1:0]      wr_ready,
    input  logic [NUM_WR_CH*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR_CH*DATA_W-1:0] wr_data,
    output logic                      sram_read_enable,
    output logic [ADDR_W-1:0]         sram_r_addr,
    input  logic [DATA_W-1:0]         sram_rd_data,
    output logic                      sram_write_enable,
    output logic [ADDR_W-1:0]         sram_w_addr,
    output logic [DATA_W-1:0]         sram_w_data,
    output logic [2:0]                grant_ch
);

    localparam int PTR_W  = (NUM_WR_CH > 1) ? $clog2(NUM_WR_CH) : 1;
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(NUM_WR_CH - 1);
    localparam logic [PTR_W:0]    NUM_CH   = (PTR_W + 1)'(NUM_WR_CH);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [WAIT_W-1:0]     waitCnt_q, waitCnt_d;
    logic [RD_LATENCY-1:0] rdPipe_q;
    logic                  sramRdEn_q, sramWrEn_q;
    logic [ADDR_W-1:0]     sramRAddr_q, sramWAddr_q;
    logic [DATA_W-1:0]     sramWData_q;
    logic                  rdDataValid_q;
    logic [DATA_W-1:0]     rdData_q;
    logic [PTR_W-1:0]      grantCh_q;

    logic [PTR_W-1:0] winCh;
    logic             winFound;
    logic [PTR_W:0]   idx;
    logic             anyWr, forceWr, wrGo, rdHs;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        winCh    = ptr_q;
        winFound = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_WR_CH; i++) begin
            idx = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!winFound && wr_valid[idx[PTR_W-1:0]]) begin
                winFound = 1'b1;
                winCh    = idx[PTR_W-1:0];
            end
        end
    end

    // Reads win unless a pending write has been blocked for MAX_WAIT cycles.
    always_comb begin
        anyWr     = |wr_valid;
        forceWr   = (MAX_WAIT != 0) && (waitCnt_q == WAIT_MAX) && anyWr;
        rd_ready  = !forceWr;
        rdHs      = rd_valid && rd_ready;
        wrGo      = anyWr && (forceWr || !rd_valid);
        wr_ready  = '0;
        if (wrGo) begin
            wr_ready[winCh] = 1'b1;
        end
        ptr_d     = wrGo ? winCh : ptr_q;
        waitCnt_d = waitCnt_q;
        if (wrGo || !anyWr) begin
            waitCnt_d = '0;
        end else if (waitCnt_q != WAIT_MAX) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= PTR_RST;
            waitCnt_q     <= '0;
            rdPipe_q      <= '0;
            sramRdEn_q    <= 1'b0;
            sramWrEn_q    <= 1'b0;
            sramRAddr_q   <= '0;
            sramWAddr_q   <= '0;
            sramWData_q   <= '0;
            rdDataValid_q <= 1'b0;
            rdData_q      <= '0;
            grantCh_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            waitCnt_q  <= waitCnt_d;
            sramRdEn_q <= rdHs;
            sramWrEn_q <= wrGo;
            if (rdHs) begin
                sramRAddr_q <= rd_addr;
            end
            if (wrGo) begin
                sramWAddr_q <= wr_addr[winCh*ADDR_W +: ADDR_W];
                sramWData_q <= wr_data[winCh*DATA_W +: DATA_W];
                grantCh_q   <= winCh;
            end
            // Tag reaches the last stage in the cycle the SRAM data is valid.
            rdPipe_q[0] <= sramRdEn_q;
            for (int k = 1; k < RD_LATENCY; k++) begin
                rdPipe_q[k] <= rdPipe_q[k-1];
            end
            rdDataValid_q <= rdPipe_q[RD_LATENCY-1];
            if (rdPipe_q[RD_LATENCY-1]) begin
                rdData_q <= sram_rd_data;
            end
        end
    end

    assign sram_read_enable  = sramRdEn_q;
    assign sram_r_addr       = sramRAddr_q;
    assign sram_write_enable = sramWrEn_q;
    assign sram_w_addr       = sramWAddr_q;
    assign sram_w_data       = sramWData_q;
    assign rd_data_valid     = rdDataValid_q;
    assign rd_data           = rdData_q;
    assign grant_ch          = 3'(grantCh_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: instance A (3 ch, MAX_WAIT=4) with an SRAM
// model, instance B (3 ch, MAX_WAIT=0) sharing the same client stimulus.
module tb_sram_arbiter;

    typedef struct packed {
        logic [2:0]  ch;
        logic [19:0] addr;
        logic [15:0] data;
    } wrExp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdValid;
    logic [19:0] rdAddr;
    logic [2:0]  wrValid;
    logic [59:0] wrAddr;
    logic [47:0] wrData;

    logic        aRdReady, aRdDv, aSramRe, aSramWe;
    logic [15:0] aRdData, aSramWData, aSramRData;
    logic [2:0]  aWrReady, aGrant;
    logic [19:0] aSramRAddr, aSramWAddr;

    logic        bRdReady, bRdDv, bSramRe, bSramWe;
    logic [15:0] bRdData, bSramWData;
    logic [2:0]  bWrReady, bGrant;
    logic [19:0] bSramRAddr, bSramWAddr;

    logic [15:0] mdlD1 = 16'hDEAD;
    logic [15:0] mdlD2 = 16'hDEAD;

    int checks = 0;
    int errors = 0;
    logic [15:0] rdExpQ[$];
    wrExp_t      wrExpQ[$];

    always #5 clk = ~clk;

    sram_arbiter #(.NUM_WR_CH(3), .ADDR_W(20), .DATA_W(16), .RD_LATENCY(2), .MAX_WAIT(4)) dutA (
        .clk(clk), .rst(rst),
        .rd_valid(rdValid), .rd_ready(aRdReady), .rd_addr(rdAddr),
        .rd_data_valid(aRdDv), .rd_data(aRdData),
        .wr_valid(wrValid), .wr_ready(aWrReady), .wr_addr(wrAddr), .wr_data(wrData),
        .sram_read_enable(aSramRe), .sram_r_addr(aSramRAddr), .sram_rd_data(aSramRData),
        .sram_write_enable(aSramWe), .sram_w_addr(aSramWAddr), .sram_w_data(aSramWData),
        .grant_ch(aGrant)
    );

    sram_arbiter #(.NUM_WR_CH(3), .ADDR_W(20), .DATA_W(16), .RD_LATENCY(2), .MAX_WAIT(0)) dutB (
        .clk(clk), .rst(rst),
        .rd_valid(rdValid), .rd_ready(bRdReady), .rd_addr(rdAddr),
        .rd_data_valid(bRdDv), .rd_data(bRdData),
        .wr_valid(wrValid), .wr_ready(bWrReady), .wr_addr(wrAddr), .wr_data(wrData),
        .sram_read_enable(bSramRe), .sram_r_addr(bSramRAddr), .sram_rd_data(16'h0000),
        .sram_write_enable(bSramWe), .sram_w_addr(bSramWAddr), .sram_w_data(bSramWData),
        .grant_ch(bGrant)
    );

    function automatic logic [15:0] memModel(input logic [19:0] a);
        if (a == 20'h00ABC) return 16'h1234;
        return a[15:0] + 16'h0100;
    endfunction

    // SRAM model with two cycles from read enable to valid data.
    always @(posedge clk) begin
        mdlD1 <= aSramRe ? memModel(aSramRAddr) : 16'hDEAD;
        mdlD2 <= mdlD1;
    end
    assign aSramRData = mdlD2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs;
        rdValid = 1'b0;
        rdAddr  = '0;
        wrValid = '0;
        for (int i = 0; i < 3; i++) begin
            wrAddr[i*20 +: 20] = 20'h00100 + 20'(i);
            wrData[i*16 +: 16] = 16'hA000 + 16'(i << 8);
        end
    endtask

    task automatic doReset;
        idleInputs();
        rdExpQ.delete();
        wrExpQ.delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idleInputs();
        rst = 1'b1;
        #2;
        checks++;
        if ({aSramRe, aSramWe, aSramRAddr, aSramWAddr, aSramWData, aRdDv, aRdData, aGrant} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got re=%b we=%b raddr=%h waddr=%h wdata=%h dv=%b rdata=%h grant=%0d required all zero",
                     aSramRe, aSramWe, aSramRAddr, aSramWAddr, aSramWData, aRdDv, aRdData, aGrant);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (aRdReady !== 1'b1 || aWrReady !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got rd_ready=%b wr_ready=%b required 1 000", aRdReady, aWrReady);
        end
    endtask

    task automatic test_single_read;
        doReset();
        rdValid = 1'b1;
        rdAddr  = 20'h00ABC;
        #1;
        checks++;
        if (aRdReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_rd_ready: got %b required 1", aRdReady);
        end
        rdExpQ.push_back(16'h1234);
        for (int c = 1; c <= 6; c++) begin
            tick();
            rdValid = 1'b0;
            if (c == 1) begin
                checks++;
                if (aSramRe !== 1'b1 || aSramRAddr !== 20'h00ABC) begin
                    errors++;
                    $display("[TB] FAIL single_rd_cmd: got re=%b addr=%h required 1 00abc", aSramRe, aSramRAddr);
                end
            end
            checks++;
            if (aRdDv !== (c == 4)) begin
                errors++;
                $display("[TB] FAIL single_rd_valid: cycle %0d got %b required %b", c, aRdDv, (c == 4));
            end
            if (aRdDv === 1'b1 && rdExpQ.size() > 0) begin
                logic [15:0] exp = rdExpQ.pop_front();
                checks++;
                if (aRdData !== exp) begin
                    errors++;
                    $display("[TB] FAIL single_rd_data: got %h required %h", aRdData, exp);
                end
            end
        end
        checks++;
        if (rdExpQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_rd_drain: %0d reads outstanding, required 0", rdExpQ.size());
        end
    endtask

    task automatic test_round_robin;
        doReset();
        wrValid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            logic [2:0] expCh;
            logic [2:0] expMask;
            wrExp_t     got;
            wrExp_t     exp;
            #1;
            expCh   = 3'(c % 3);
            expMask = 3'b001 << expCh;
            checks++;
            if (aWrReady !== expMask || aRdReady !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_ready: cycle %0d got wr_ready=%b rd_ready=%b required %b 1", c, aWrReady, aRdReady, expMask);
            end
            wrExpQ.push_back({expCh, wrAddr[expCh*20 +: 20], wrData[expCh*16 +: 16]});
            tick();
            exp = wrExpQ.pop_front();
            got = {aGrant, aSramWAddr, aSramWData};
            checks++;
            if (aSramWe !== 1'b1 || got !== exp) begin
                errors++;
                $display("[TB] FAIL rr_cmd: cycle %0d got we=%b ch=%0d addr=%h data=%h required 1 ch=%0d addr=%h data=%h",
                         c, aSramWe, got.ch, got.addr, got.data, exp.ch, exp.addr, exp.data);
            end
            wrData[expCh*16 +: 16] = wrData[expCh*16 +: 16] + 16'h0001;
        end
        idleInputs();
    endtask

    task automatic test_starvation;
        doReset();
        rdValid = 1'b1;
        rdAddr  = 20'h00040;
        wrValid = 3'b010;
        wrAddr[20 +: 20] = 20'h00222;
        wrData[16 +: 16] = 16'hBEEF;
        for (int c = 0; c < 10; c++) begin
            logic expW;
            #1;
            expW = (c % 5 == 4);
            checks++;
            if (aRdReady !== !expW || aWrReady !== (expW ? 3'b010 : 3'b000)) begin
                errors++;
                $display("[TB] FAIL guard_ready: cycle %0d got rd_ready=%b wr_ready=%b required %b %b",
                         c, aRdReady, aWrReady, !expW, (expW ? 3'b010 : 3'b000));
            end
            checks++;
            if (bRdReady !== 1'b1 || bWrReady !== 3'b000) begin
                errors++;
                $display("[TB] FAIL noguard_ready: cycle %0d got rd_ready=%b wr_ready=%b required 1 000", c, bRdReady, bWrReady);
            end
            tick();
            checks++;
            if (aSramWe !== expW || aSramRe !== !expW) begin
                errors++;
                $display("[TB] FAIL guard_cmd: cycle %0d got we=%b re=%b required %b %b", c, aSramWe, aSramRe, expW, !expW);
            end
        end
        rdValid = 1'b0;
        #1;
        checks++;
        if (bWrReady !== 3'b010 || aWrReady !== 3'b010) begin
            errors++;
            $display("[TB] FAIL noguard_release: got b=%b a=%b required 010 010", bWrReady, aWrReady);
        end
        tick();
        checks++;
        if (bSramWe !== 1'b1 || bSramWAddr !== 20'h00222 || bSramWData !== 16'hBEEF || bGrant !== 3'd1) begin
            errors++;
            $display("[TB] FAIL noguard_cmd: got we=%b addr=%h data=%h ch=%0d required 1 00222 beef 1",
                     bSramWe, bSramWAddr, bSramWData, bGrant);
        end
        idleInputs();
    endtask

    task automatic test_read_burst;
        doReset();
        for (int c = 0; c < 16; c++) begin
            logic expV;
            if (c < 8) begin
                rdValid = 1'b1;
                rdAddr  = 20'(c);
                rdExpQ.push_back(16'h0100 + 16'(c));
            end else begin
                rdValid = 1'b0;
            end
            #1;
            if (c < 8) begin
                checks++;
                if (aRdReady !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL burst_ready: cycle %0d got %b required 1", c, aRdReady);
                end
            end
            tick();
            expV = (c + 1 >= 4) && (c + 1 <= 11);
            checks++;
            if (aRdDv !== expV) begin
                errors++;
                $display("[TB] FAIL burst_valid: cycle %0d got %b required %b", c + 1, aRdDv, expV);
            end
            if (aRdDv === 1'b1) begin
                checks++;
                if (rdExpQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL burst_data: got %h required no data", aRdData);
                end else begin
                    logic [15:0] exp = rdExpQ.pop_front();
                    if (aRdData !== exp) begin
                        errors++;
                        $display("[TB] FAIL burst_data: got %h required %h", aRdData, exp);
                    end
                end
            end
        end
        checks++;
        if (rdExpQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL burst_drain: %0d reads outstanding, required 0", rdExpQ.size());
        end
        idleInputs();
    endtask

    task automatic test_back_to_back;
        doReset();
        rdValid = 1'b1;
        rdAddr  = 20'h00007;
        wrValid = 3'b111;
        for (int c = 0; c < 15; c++) begin
            logic       expW;
            logic [2:0] expMask;
            #1;
            expW    = (c % 5 == 4);
            expMask = expW ? (3'b001 << ((c / 5) % 3)) : 3'b000;
            checks++;
            if (aWrReady !== expMask || aRdReady !== !expW) begin
                errors++;
                $display("[TB] FAIL b2b_ready: cycle %0d got wr_ready=%b rd_ready=%b required %b %b",
                         c, aWrReady, aRdReady, expMask, !expW);
            end
            tick();
        end
        idleInputs();
    endtask

    task automatic test_reset_midflight;
        doReset();
        rdValid = 1'b1;
        rdAddr  = 20'h00005;
        tick();
        rdAddr  = 20'h00006;
        tick();
        rdValid = 1'b0;
        rst     = 1'b1;
        #1;
        checks++;
        if ({aSramRe, aSramWe, aSramRAddr, aSramWAddr, aSramWData, aRdDv, aRdData, aGrant} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got re=%b raddr=%h dv=%b rdata=%h required all zero",
                     aSramRe, aSramRAddr, aRdDv, aRdData);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (aRdDv !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_stale: cycle %0d got rd_data_valid=%b required 0", c, aRdDv);
            end
        end
        wrValid = 3'b111;
        #1;
        checks++;
        if (aWrReady !== 3'b001) begin
            errors++;
            $display("[TB] FAIL midreset_first_grant: got %b required 001", aWrReady);
        end
        tick();
        checks++;
        if (aSramWe !== 1'b1 || aGrant !== 3'd0 || aSramWAddr !== 20'h00100) begin
            errors++;
            $display("[TB] FAIL midreset_cmd: got we=%b ch=%0d addr=%h required 1 0 00100", aSramWe, aGrant, aSramWAddr);
        end
        idleInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idleInputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_starvation();
        test_read_burst();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
